// File: rtl/serial_link_pkg.sv
// Framing constants and state encoding shared by the serial link transmitter and receiver.
package serial_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } link_state_e;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in/parallel-out right-shift register: each enabled edge puts the new bit in the MSB,
// so an LSB-first word is fully aligned after WIDTH shifts.
module sipo_shift_reg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             en_i,
  input  logic             si_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] shreg_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      shreg_q <= '0;
    end else if (en_i) begin
      shreg_q <= {si_i, shreg_q[WIDTH-1:1]};
    end
  end

  assign q_o = shreg_q;

endmodule

// File: rtl/serial_word_receiver.sv
// Framed serial word receiver: start(1), WIDTH data bits LSB first, optional even parity, stop(0).
// Define PARITY_CHECK_EN to add the parity bit and its check.
module serial_word_receiver
  import serial_link_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             shift,
  input  logic             SI,
  output logic [WIDTH-1:0] A,
  output logic             valid,
  output logic             busy,
  output logic             ferr
);

  localparam int unsigned     CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  link_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             shift_en;
  logic [WIDTH-1:0] shreg;
`ifdef PARITY_CHECK_EN
  logic             perr_q, perr_d;
`endif

  sipo_shift_reg #(.WIDTH(WIDTH)) u_sipo (
    .clk_i  (clk),
    .rstn_i (rstn),
    .en_i   (shift_en),
    .si_i   (SI),
    .q_o    (shreg)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    shift_en = 1'b0;
`ifdef PARITY_CHECK_EN
    perr_d   = perr_q;
`endif
    if (shift) begin
      case (state_q)
        ST_IDLE: begin
          if (SI == START_BIT) begin
            state_d = ST_DATA;
            cnt_d   = '0;
          end
        end
        ST_DATA: begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
`ifdef PARITY_CHECK_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
`ifdef PARITY_CHECK_EN
        ST_PARITY: begin
          // Even parity: received bit must equal the XOR of the data bits.
          perr_d  = SI ^ (^shreg);
          state_d = ST_STOP;
        end
`endif
        ST_STOP: begin
          state_d = ST_IDLE;
`ifdef PARITY_CHECK_EN
          if ((SI != STOP_BIT) || perr_q) begin
`else
          if (SI != STOP_BIT) begin
`endif
            ferr_d = 1'b1;
          end else begin
            a_d     = shreg;
            valid_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef PARITY_CHECK_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef PARITY_CHECK_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign A     = a_q;
  assign valid = valid_q;
  assign ferr  = ferr_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_word_receiver.sv
// Self-checking bench for serial_word_receiver: directed frames plus random frame traffic
// checked against a frame-level expectation of A/valid/ferr/busy.
module tb_serial_word_receiver;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         shift = 1'b0;
  logic         SI = 1'b0;
  logic [W-1:0] A;
  logic         valid, busy, ferr;

  int unsigned  n_checks = 0;
  int unsigned  n_fail = 0;
  logic [W-1:0] exp_a = '0;

  serial_word_receiver #(.WIDTH(W)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .shift (shift),
    .SI    (SI),
    .A     (A),
    .valid (valid),
    .busy  (busy),
    .ferr  (ferr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic b, input logic v, input logic f);
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".valid"}, 32'(valid), 32'(v));
    chk({tag, ".ferr"}, 32'(ferr), 32'(f));
    chk({tag, ".A"}, 32'(A), 32'(exp_a));
  endtask

  task automatic step(input logic sh, input logic si);
    shift = sh;
    SI    = si;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 1) step(1'b1, 1'b0);
      else step(1'b0, 1'($urandom_range(0, 1)));
      chk_outs("idle", 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Sends one whole frame; the expected outcome follows from the frame contents alone.
  task automatic send_frame(input logic [W-1:0] d, input logic bad_stop,
                            input logic par_flip, input logic gap);
    logic bits[$];
    logic good;
    bits.push_back(1'b1);
    for (int unsigned i = 0; i < W; i++) bits.push_back(d[i]);
    good = !bad_stop;
`ifdef PARITY_CHECK_EN
    bits.push_back((^d) ^ par_flip);
    good = good && !par_flip;
`else
    if (par_flip) good = good;
`endif
    bits.push_back(bad_stop);
    for (int i = 0; i < bits.size(); i++) begin
      if (gap) begin
        step(1'b0, 1'($urandom_range(0, 1)));
        chk_outs("gap", i != 0, 1'b0, 1'b0);
      end
      step(1'b1, bits[i]);
      if (i == bits.size() - 1) begin
        if (good) exp_a = d;
        chk_outs("stop", 1'b0, good, !good);
      end else begin
        chk_outs("bit", 1'b1, 1'b0, 1'b0);
      end
    end
  endtask

  initial begin
    // Reset, checked while asserted
    rstn = 1'b0;
    #10;
    chk_outs("reset", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0);
      chk_outs("idle0", 1'b0, 1'b0, 1'b0);
    end

    // Good frame, then gapped version of the same frame
    send_frame(4'b1010, 1'b0, 1'b0, 1'b0);
    chk("good1010.A", 32'(A), 32'h0000000a);
    idle(2);
    exp_a = 4'b1010;
    send_frame(4'b1010, 1'b0, 1'b0, 1'b1);
    idle(1);

    // Framing error, then a good 0011 frame
    send_frame(4'b0011, 1'b1, 1'b0, 1'b0);
    chk("ferr.Ahold", 32'(A), 32'h0000000a);
    step(1'b1, 1'b0);
    chk_outs("after_ferr", 1'b0, 1'b0, 1'b0);
    send_frame(4'b0011, 1'b0, 1'b0, 1'b0);
    idle(1);

    // Back-to-back frames with no idle bit
    send_frame(4'b0110, 1'b0, 1'b0, 1'b0);
    send_frame(4'b1001, 1'b0, 1'b0, 1'b0);
    chk("b2b.A", 32'(A), 32'h00000009);

    // Third frame interrupted by reset after two data bits
    step(1'b1, 1'b1);
    chk_outs("part.start", 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1);
    chk_outs("part.d0", 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk_outs("part.d1", 1'b1, 1'b0, 1'b0);
    shift = 1'b0;
    #2;
    rstn = 1'b0;
    exp_a = '0;
    #1;
    chk_outs("midreset", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    idle(1);
    send_frame(4'b0101, 1'b0, 1'b0, 1'b0);
    idle(1);

`ifdef PARITY_CHECK_EN
    send_frame(4'b1010, 1'b0, 1'b0, 1'b0);
    chk("par.good.A", 32'(A), 32'h0000000a);
    idle(1);
    send_frame(4'b0110, 1'b0, 1'b1, 1'b0);
    chk("par.bad.A", 32'(A), 32'h0000000a);
    idle(1);
`endif

    // Random frame traffic
    for (int n = 0; n < 40; n++) begin
      send_frame(W'($urandom_range(0, (1 << W) - 1)),
                 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 2) == 0));
      idle($urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
